// File: rtl/pattern_sweep_ctrl_if.sv
// Handshake and stimulus bundle between the sweep controller and its environment.
interface pattern_sweep_ctrl_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             start;
  logic             abort;
  logic             dut_out;
  logic             rec_ready;
  logic [WIDTH-1:0] dut_in;
  logic             rec_valid;
  logic [WIDTH-1:0] rec_pattern;
  logic             rec_response;
  logic [WIDTH:0]   ones_count;
  logic             busy;
  logic             done;

  modport master (
    input  start, abort, dut_out, rec_ready,
    output dut_in, rec_valid, rec_pattern, rec_response, ones_count, busy, done
  );

  modport slave (
    output start, abort, dut_out, rec_ready,
    input  dut_in, rec_valid, rec_pattern, rec_response, ones_count, busy, done
  );
endinterface

// File: rtl/pattern_sweep_ctrl.sv
// Exhaustive stimulus sweep: drives every pattern, waits a settle time, samples the
// single-bit response and hands each {pattern, response} record out over valid/ready.
module pattern_sweep_ctrl #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input logic                  CK,
  input logic                  reset,
  pattern_sweep_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StSettle, StEmit, StDone} state_e;

  localparam logic [7:0]       SettleLoad = 8'(SETTLE - 1);
  localparam logic [WIDTH-1:0] PatAllOnes = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   OnesMax    = {1'b1, {WIDTH{1'b0}}};

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dut_in_q, dut_in_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             resp_q, resp_d;
  logic [WIDTH:0]   ones_q, ones_d;
  logic             busy_q, valid_q, done_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dut_in_d = dut_in_q;
    pat_d    = pat_q;
    resp_d   = resp_q;
    ones_d   = ones_q;
    unique case (state_q)
      StIdle: begin
        // abort wins over a simultaneous start
        if (bus.start && !bus.abort) begin
          state_d  = StSettle;
          dut_in_d = '0;
          cnt_d    = SettleLoad;
          ones_d   = '0;
        end
      end
      StSettle: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (cnt_q == 8'd0) begin
          pat_d   = dut_in_q;
          resp_d  = bus.dut_out;
          state_d = StEmit;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StEmit: begin
        // an abort drops the pending record even if it is accepted this cycle
        if (bus.abort) begin
          state_d = StIdle;
        end else if (bus.rec_ready) begin
          if (resp_q && (ones_q != OnesMax)) begin
            ones_d = ones_q + (WIDTH + 1)'(1);
          end
          if (pat_q == PatAllOnes) begin
            state_d = StDone;
          end else begin
            dut_in_d = dut_in_q + WIDTH'(1);
            cnt_d    = SettleLoad;
            state_d  = StSettle;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      dut_in_q <= '0;
      pat_q    <= '0;
      resp_q   <= 1'b0;
      ones_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dut_in_q <= dut_in_d;
      pat_q    <= pat_d;
      resp_q   <= resp_d;
      ones_q   <= ones_d;
      busy_q   <= (state_d != StIdle);
      valid_q  <= (state_d == StEmit);
      done_q   <= (state_d == StDone);
    end
  end

  assign bus.dut_in       = dut_in_q;
  assign bus.rec_valid    = valid_q;
  assign bus.rec_pattern  = pat_q;
  assign bus.rec_response = resp_q;
  assign bus.ones_count   = ones_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_pattern_sweep_ctrl.sv
// Self-checking bench for pattern_sweep_ctrl: a default instance (4-bit, settle 1) and a
// 3-bit instance with settle 3 whose response lags the stimulus by one cycle.
module tb_pattern_sweep_ctrl;

  localparam int AW = 4;
  localparam int AS = 1;
  localparam int BW = 3;
  localparam int BS = 3;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  pattern_sweep_ctrl_if #(.WIDTH(AW)) a_if ();
  pattern_sweep_ctrl_if #(.WIDTH(BW)) b_if ();

  pattern_sweep_ctrl #(.WIDTH(AW), .SETTLE(AS)) u_dut_a (
    .CK   (clk),
    .reset(rst_n),
    .bus  (a_if)
  );

  pattern_sweep_ctrl #(.WIDTH(BW), .SETTLE(BS)) u_dut_b (
    .CK   (clk),
    .reset(rst_n),
    .bus  (b_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Response models of the block under test for instance A
  int   a_mode;   // 0: constant, 1: dut_in[0], 2: lookup table
  logic a_const;
  logic a_tbl [16];

  always_comb begin
    case (a_mode)
      0:       a_if.dut_out = a_const;
      1:       a_if.dut_out = a_if.dut_in[0];
      default: a_if.dut_out = a_tbl[a_if.dut_in];
    endcase
  end

  // Instance B sees parity of its stimulus one cycle late
  always_ff @(posedge clk) b_if.dut_out <= ^b_if.dut_in;

  function automatic logic a_resp(input int p);
    logic [3:0] idx;
    idx = p[3:0];
    case (a_mode)
      0:       return a_const;
      1:       return idx[0];
      default: return a_tbl[idx];
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_start();
    a_if.start = 1'b1;
    step();
    a_if.start = 1'b0;
  endtask

  task automatic a_abort();
    a_if.abort = 1'b1;
    step();
    a_if.abort = 1'b0;
  endtask

  task automatic a_wait_pat(input int p);
    bit ok = 0;
    for (int g = 0; g < 300 && !ok; g++) begin
      if (a_if.rec_valid && (32'(a_if.rec_pattern) == p)) ok = 1;
      else step();
    end
    chk("wait for pattern", 32'(ok), 1);
  endtask

  // Full sweep checked against the record sequence the sweep rules imply
  task automatic a_sweep(input int ready_pct, input int poke_at);
    int         exp_pat = 0;
    int         ones = 0;
    int         since = 0;
    int         edges;
    bit         hs, pv, fin;
    logic [3:0] pp;
    logic       pr;
    fin = 0;
    a_start();
    edges = 1;
    for (int g = 0; g < 2000 && !fin; g++) begin
      a_if.rec_ready = ($urandom_range(99) < ready_pct);
      a_if.start     = (edges == poke_at);
      hs = a_if.rec_valid && a_if.rec_ready;
      pv = a_if.rec_valid;
      pp = a_if.rec_pattern;
      pr = a_if.rec_response;
      if (hs) begin
        chk("rec_pattern", 32'(a_if.rec_pattern), exp_pat);
        chk("rec_response", 32'(a_if.rec_response), 32'(a_resp(exp_pat)));
        if (a_resp(exp_pat)) ones++;
      end
      step();
      edges++;
      since++;
      a_if.start = 1'b0;
      if (hs) begin
        since = 0;
        if (exp_pat == 15) begin
          fin = 1;
          chk("done after last record", 32'(a_if.done), 1);
          chk("ones_count at done", 32'(a_if.ones_count), ones);
          if (ready_pct == 100) chk("sweep length", edges, 16 * (AS + 1) + 1);
          step();
          chk("done one cycle", 32'(a_if.done), 0);
          chk("idle after done", 32'(a_if.busy), 0);
          chk("ones_count held", 32'(a_if.ones_count), ones);
        end
        exp_pat++;
      end else begin
        if (pv) begin
          chk("stall valid held", 32'(a_if.rec_valid), 1);
          chk("stall pattern held", 32'(a_if.rec_pattern), 32'(pp));
          chk("stall response held", 32'(a_if.rec_response), 32'(pr));
        end else if (a_if.rec_valid) begin
          chk("settle latency", since, AS);
        end
        if (a_if.done) chk("early done", 32'(a_if.done), 0);
      end
    end
    chk("sweep completes", 32'(fin), 1);
  endtask

  typedef struct {
    logic       start;
    logic       abort;
    logic       ready;
    logic       dout;
    logic       busy;
    logic       valid;
    logic       done;
    logic [3:0] dut_in;
    logic [4:0] ones;
    logic [3:0] pat;
    logic       resp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int  dcnt;
    bit  ok;
    logic [2:0] bk;
    int  since, edges;
    bit  fin;

    // start abort ready dout | busy valid done dut_in ones pat resp
    vecs[0] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1};
    vecs[4] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1};
    vecs[5] = '{1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0};
    vecs[6] = '{0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 0};
    vecs[7] = '{0, 0, 1, 0, 1, 0, 0, 2, 1, 0, 0};
    vecs[8] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[9] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

    rst_n = 1'b0;
    a_mode = 0;
    a_const = 1'b0;
    for (int i = 0; i < 16; i++) a_tbl[i] = 1'b0;
    a_if.start = 1'b0;
    a_if.abort = 1'b0;
    a_if.rec_ready = 1'b0;
    b_if.start = 1'b0;
    b_if.abort = 1'b0;
    b_if.rec_ready = 1'b1;
    #3;
    chk("reset busy", 32'(a_if.busy), 0);
    chk("reset valid", 32'(a_if.rec_valid), 0);
    chk("reset done", 32'(a_if.done), 0);
    chk("reset dut_in", 32'(a_if.dut_in), 0);
    chk("reset ones", 32'(a_if.ones_count), 0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Cycle-by-cycle table: start/abort priority, stalls, start while busy, abort
    for (int i = 0; i < 10; i++) begin
      a_if.start     = vecs[i].start;
      a_if.abort     = vecs[i].abort;
      a_if.rec_ready = vecs[i].ready;
      a_const        = vecs[i].dout;
      step();
      chk($sformatf("vec%0d busy", i), 32'(a_if.busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d valid", i), 32'(a_if.rec_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d done", i), 32'(a_if.done), 32'(vecs[i].done));
      chk($sformatf("vec%0d ones", i), 32'(a_if.ones_count), 32'(vecs[i].ones));
      if (vecs[i].busy)
        chk($sformatf("vec%0d dut_in", i), 32'(a_if.dut_in), 32'(vecs[i].dut_in));
      if (vecs[i].valid) begin
        chk($sformatf("vec%0d pattern", i), 32'(a_if.rec_pattern), 32'(vecs[i].pat));
        chk($sformatf("vec%0d response", i), 32'(a_if.rec_response), 32'(vecs[i].resp));
      end
    end
    a_if.start = 1'b0;
    a_abort();
    chk("idle after abort", 32'(a_if.busy), 0);

    // Nominal sweep with alternating response, plus an ignored start mid-sweep
    a_mode = 1;
    a_sweep(100, 7);

    // Consumer stall at pattern 5
    a_mode = 0;
    a_const = 1'b1;
    a_if.rec_ready = 1'b1;
    a_start();
    a_wait_pat(5);
    a_if.rec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold valid", 32'(a_if.rec_valid), 1);
      chk("hold pattern 5", 32'(a_if.rec_pattern), 5);
      chk("hold dut_in 5", 32'(a_if.dut_in), 5);
    end
    a_if.rec_ready = 1'b1;
    step();
    chk("valid drops after accept", 32'(a_if.rec_valid), 0);
    a_wait_pat(6);
    chk("next pattern 6", 32'(a_if.rec_pattern), 6);
    a_abort();

    // Abort during EMIT of pattern 9 with the consumer ready
    a_start();
    a_wait_pat(9);
    a_if.abort = 1'b1;
    step();
    a_if.abort = 1'b0;
    chk("abort busy", 32'(a_if.busy), 0);
    chk("abort valid", 32'(a_if.rec_valid), 0);
    chk("abort ones", 32'(a_if.ones_count), 9);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_if.done || a_if.busy) dcnt++;
      step();
    end
    chk("no activity after abort", dcnt, 0);

    // Asynchronous reset mid-sweep at pattern 12
    a_start();
    ok = 0;
    for (int g = 0; g < 300 && !ok; g++) begin
      if (32'(a_if.dut_in) == 12) ok = 1;
      else step();
    end
    chk("reach pattern 12", 32'(ok), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst dut_in", 32'(a_if.dut_in), 0);
    chk("async rst ones", 32'(a_if.ones_count), 0);
    chk("async rst busy", 32'(a_if.busy), 0);
    chk("async rst valid", 32'(a_if.rec_valid), 0);
    chk("async rst pattern", 32'(a_if.rec_pattern), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("no resume after reset", 32'(a_if.busy), 0);
    a_start();
    a_wait_pat(0);
    chk("restart at pattern 0", 32'(a_if.dut_in), 0);
    a_abort();

    // Random response tables and random consumer back-pressure
    a_mode = 2;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 16; i++) a_tbl[i] = logic'($urandom_range(1));
      a_sweep(60, -1);
    end

    // Instance B: settle 3, lagging response, consumer always ready
    b_if.start = 1'b1;
    step();
    b_if.start = 1'b0;
    since = 0;
    edges = 1;
    bk = 3'd0;
    fin = 0;
    for (int g = 0; g < 200 && !fin; g++) begin
      ok = b_if.rec_valid && b_if.rec_ready;
      if (ok) begin
        chk("B pattern", 32'(b_if.rec_pattern), 32'(bk));
        chk("B settled response", 32'(b_if.rec_response), 32'(^bk));
      end
      step();
      since++;
      edges++;
      if (ok) begin
        chk("B record spacing", since, BS + 1);
        since = 0;
        if (bk == 3'd7) begin
          fin = 1;
          chk("B done", 32'(b_if.done), 1);
          chk("B sweep length", edges, 8 * (BS + 1) + 1);
          chk("B ones", 32'(b_if.ones_count), 4);
        end
        bk = bk + 3'd1;
      end
    end
    chk("B sweep completes", 32'(fin), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pattern_sweep_ctrl.md
PATTERN_SWEEP_CTRL -- requirements
Module: pattern_sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: width of the DUT stimulus pattern; legal range 1..16.
REQ-002 Parameter SETTLE, default 1: cycles the pattern is held before sampling; legal range 1..255.
REQ-003 CK  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  pulse in IDLE begins an exhaustive sweep.
REQ-006 abort  input  1  terminates the sweep in progress.
REQ-007 dut_out  input  1  single-bit response of the block under test.
REQ-008 dut_in  output  WIDTH  stimulus pattern driven to the block under test.
REQ-009 rec_valid  output  1  a record is available.
REQ-010 rec_ready  input  1  the consumer accepts the record.
REQ-011 rec_pattern  output  WIDTH  pattern of the current record.
REQ-012 rec_response  output  1  sampled dut_out for rec_pattern.
REQ-013 ones_count  output  WIDTH+1  number of accepted records with rec_response=1 in the current or last sweep.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on sweep completion.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, SETTLE, EMIT, DONE.
REQ-017 IDLE with start=1, abort=0 SHALL move to SETTLE, load dut_in=0, load the settle counter with SETTLE-1, and clear ones_count.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 SETTLE SHALL decrement the counter each cycle and remain for exactly SETTLE cycles; dut_in SHALL stay constant throughout.
REQ-020 On the last SETTLE cycle, the block SHALL capture dut_out into rec_response and dut_in into rec_pattern, then move to EMIT.
REQ-021 EMIT SHALL assert rec_valid and hold rec_pattern and rec_response stable until rec_valid and rec_ready are both high at a rising edge.
REQ-022 On handshake: ones_count SHALL increment if rec_response=1, saturating at 2^WIDTH.
REQ-023 On handshake with rec_pattern not all-ones: dut_in SHALL increment by 1, the counter SHALL reload with SETTLE-1, and the FSM SHALL return to SETTLE.
REQ-024 On handshake with rec_pattern all-ones: the FSM SHALL move to DONE; dut_in SHALL not wrap.
REQ-025 DONE SHALL assert done for exactly one cycle and then move to IDLE; ones_count SHALL hold until the next start.
REQ-026 rec_ready while rec_valid=0 SHALL have no effect.
REQ-027 abort=1 in SETTLE, EMIT or DONE SHALL force IDLE on the next edge.
REQ-028 On abort: rec_valid=0, done not pulsed, ones_count held, and any pending record dropped, even if a handshake occurs in the same cycle.
REQ-029 In IDLE, abort SHALL take priority over a simultaneous start; the FSM SHALL remain in IDLE.
REQ-030 Throughput SHALL be one record per SETTLE+1 cycles when rec_ready is held high, giving a full sweep of 2^WIDTH*(SETTLE+1)+1 cycles from start to the done pulse.

Reset
REQ-031 While reset=0, the block SHALL force state=IDLE, dut_in=0, rec_valid=0, rec_pattern=0, rec_response=0, ones_count=0, busy=0, done=0, counter=0.
REQ-032 Reset asserted mid-sweep SHALL take effect immediately, without waiting for a clock edge.
REQ-033 After reset deasserts, the block SHALL await a new start; no partial sweep resumes.

Verification
REQ-034 Defaults, dut_out = dut_in[0], rec_ready=1, start pulse -> 16 records with patterns 0..15 in order and responses alternating 0,1; ones_count=8; done pulse 33 cycles after start.
REQ-035 dut_out=1, rec_ready low for 3 cycles at pattern 5 -> rec_valid held with rec_pattern=5 unchanged; dut_in stays 5; next record has pattern 6.
REQ-036 abort during EMIT of pattern 9 with rec_ready=1 -> record 9 not counted; IDLE next cycle; done never pulses; ones_count=9 with dut_out=1.
REQ-037 start and abort high together in IDLE -> busy stays 0 and no record is emitted; start alone while busy -> sweep unaffected.
REQ-038 reset=0 asynchronously at pattern 12 -> all outputs take reset values before the next CK edge; a subsequent start begins again at pattern 0.
REQ-039 SETTLE=3, dut_out changes 1 cycle after dut_in -> captured response reflects the settled value; each record spans 4 cycles.
